fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the program counter and drives the byte-addressed instruction memory (combinational read, big-endian 4-byte word).
- Latches each fetched word, its PC+4 and a valid bit for the decode/control stage; id_opcode feeds the control unit directly.
- Accepts stall, flush and branch/jump redirects from downstream; MIPS single delay slot is preserved, so a redirect never squashes the delay-slot fetch.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
MEM_BYTES, 512, instruction memory size in bytes; fetch is legal only while pc+3 < MEM_BYTES.
NOP_WORD, 32'h00000000, word inserted into IF/ID on flush/bubble (SLL $0,$0,0).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high; clears all state immediately.
stall  in  1  hold PC and IF/ID contents this cycle.
flush  in  1  load NOP_WORD into IF/ID, id_valid=0.
branch_taken  in  1  redirect PC to branch_target.
branch_target  in  32  byte address.
jump  in  1  redirect PC to jump_target.
jump_target  in  32  byte address.
imem_addr  out  32  current PC.
imem_en  out  1  instruction memory enable.
imem_data  in  32  combinational instruction word at imem_addr.
id_instr  out  32  latched instruction.
id_pc_plus4  out  32  PC+4 of latched instruction.
id_opcode  out  6  id_instr[31:26].
id_valid  out  1  id_instr is a real fetched instruction.
halted  out  1  PC ran past memory.
misalign_err  out  1  redirect target not word-aligned (sticky).
fetch_count  out  32  number of valid words loaded into IF/ID, saturating.

Behaviour:
- Reset (async):
  - pc=RESET_PC; state=RUN.
  - id_instr=NOP_WORD, id_pc_plus4=0, id_valid=0.
  - halted=0, misalign_err=0, fetch_count=0.
- States:
  - RUN: imem_en=1.
  - HALT: imem_en=0, halted=1.
  - ERR: imem_en=0, misalign_err=1.
  - HALT and ERR are terminal until reset.
- imem_addr = pc in all states (combinational).
- RUN, per rising edge, in priority order:
  1. stall=1:
     - pc held.
     - IF/ID held, unless flush=1: then IF/ID <= NOP, id_valid=0.
     - Redirects ignored; downstream must hold them until stall=0.
  2. flush=1, stall=0:
     - IF/ID <= NOP, id_valid=0.
     - pc advances per rules 3-5 (redirects still honoured).
  3. Otherwise IF/ID <= {imem_data, pc+4}, id_valid=1; fetch_count++ (saturates at 32'hFFFFFFFF).
  4. Next pc:
     - jump=1 → jump_target (jump beats branch if both asserted).
     - else branch_taken=1 → branch_target.
     - else pc+4 (32-bit wrap ignored; HALT catches overflow first).
  5. Checks on the next pc:
     - Selected next pc[1:0]≠0 → state=ERR, pc unchanged.
     - Else next pc+3 ≥ MEM_BYTES → state=HALT, pc <= next pc.
- Fetch bounds: if the current pc is out of range while in RUN (e.g. RESET_PC misconfigured), go to HALT on the next edge without loading IF/ID.
- HALT/ERR, every edge: IF/ID <= NOP, id_valid=0; pc frozen; fetch_count frozen; stall/flush/redirect ignored.
- Latency: the word at pc appears on id_instr exactly one edge after pc is presented, if not stalled.
- Delay slot: a redirect asserted while the branch is in ID takes effect on the PC for the following fetch. The word already being fetched (PC of branch+4) is latched normally.
- Reset mid-operation: all outputs return to reset values asynchronously. The first fetch after deassertion is from RESET_PC.

Test Plan:
- Reset release, imem words W0..W3 at 0,4,8,12, no stall → id_instr=W0,W1,W2,W3 on edges 1-4; id_pc_plus4=4,8,12,16; fetch_count=4; id_valid=1 from edge 1.
- At pc=0x1C assert branch_taken with branch_target=0x14 for one cycle → IF/ID gets word@0x1C (delay slot), pc becomes 0x14; next id_instr=word@0x14.
- stall=1 for 3 cycles at pc=0x08 → imem_addr stays 0x08, id_instr/id_pc_plus4/fetch_count unchanged. Same with flush=1 on cycle 2 → id_instr=0, id_valid=0, pc still 0x08.
- jump=1 (target 0x40) and branch_taken=1 (target 0x20) in the same cycle → next pc=0x40.
- jump_target=0x42 → misalign_err=1, imem_en=0, id_valid=0 thereafter; reset clears it and pc=0.
- Sequential run from 0x1F8 with MEM_BYTES=512 → fetches 0x1F8, 0x1FC, then halted=1, imem_en=0, id_valid=0, fetch_count frozen.

Source files
------------

// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage bus: downstream control (stall, flush, redirects),
// instruction-memory port and the IF/ID register outputs.
// master = the fetch stage, slave = the surrounding pipeline and memory.
interface fetch_decode_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic        id_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target,
    input  imem_data,
    output imem_addr, imem_en,
    output id_instr, id_pc_plus4, id_opcode, id_valid,
    output halted, misalign_err, fetch_count
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target,
    output imem_data,
    input  imem_addr, imem_en,
    input  id_instr, id_pc_plus4, id_opcode, id_valid,
    input  halted, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, drives a combinational byte-addressed instruction memory and
// latches {instruction, PC+4, valid} for decode. Redirects take effect on
// the fetch after the one in flight, preserving the MIPS delay slot.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 512,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_stage_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic [31:0] count_q;
  logic        imem_en_q;
  logic        halted_q;
  logic        misalign_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] next_pc_d;
  logic        pc_in_range_d;
  logic        next_in_range_d;
  logic        next_aligned_d;

  // A whole 4-byte word starting at addr must lie inside the memory.
  function automatic logic word_in_range(input logic [31:0] addr);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return last_byte < 33'(MEM_BYTES);
  endfunction

  // Fetch counter sticks at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Next-PC selection: jump beats branch, otherwise sequential.
  always_comb begin
    pc_plus4_d = pc_q + 32'd4;
    next_pc_d  = pc_plus4_d;
    if (bus.jump) begin
      next_pc_d = bus.jump_target;
    end else if (bus.branch_taken) begin
      next_pc_d = bus.branch_target;
    end
    pc_in_range_d   = word_in_range(pc_q);
    next_in_range_d = word_in_range(next_pc_d);
    next_aligned_d  = (next_pc_d[1:0] == 2'b00);
  end

  // Fetch FSM, PC and IF/ID register with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= 32'd0;
      imem_en_q  <= 1'b1;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!pc_in_range_d) begin
            // PC already outside memory: stop without fetching.
            state_q    <= ST_HALT;
            halted_q   <= 1'b1;
            imem_en_q  <= 1'b0;
            instr_q    <= NOP_WORD;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
          end else if (bus.stall) begin
            // PC and redirects frozen; only a flush may disturb IF/ID.
            if (bus.flush) begin
              instr_q    <= NOP_WORD;
              pc_plus4_q <= 32'd0;
              valid_q    <= 1'b0;
            end
          end else begin
            if (bus.flush) begin
              instr_q    <= NOP_WORD;
              pc_plus4_q <= 32'd0;
              valid_q    <= 1'b0;
            end else begin
              instr_q    <= bus.imem_data;
              pc_plus4_q <= pc_plus4_d;
              valid_q    <= 1'b1;
              count_q    <= sat_inc(count_q);
            end
            if (!next_aligned_d) begin
              // Misaligned target: keep the PC, lock up until reset.
              state_q    <= ST_ERR;
              misalign_q <= 1'b1;
              imem_en_q  <= 1'b0;
            end else begin
              pc_q <= next_pc_d;
              if (!next_in_range_d) begin
                state_q   <= ST_HALT;
                halted_q  <= 1'b1;
                imem_en_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          // HALT/ERR are terminal: feed bubbles, freeze everything else.
          instr_q    <= NOP_WORD;
          pc_plus4_q <= 32'd0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.imem_en      = imem_en_q;
  assign bus.id_instr     = instr_q;
  assign bus.id_pc_plus4  = pc_plus4_q;
  assign bus.id_opcode    = instr_q[31:26];
  assign bus.id_valid     = valid_q;
  assign bus.halted       = halted_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: a driver issues per-cycle
// control inputs and pushes the reference model's expected outputs; a
// monitor pops and compares one entry after every rising edge.
module tb_fetch_decode_stage;

  localparam int MEM_BYTES = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_decode_stage_if bus();

  fetch_decode_stage #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(MEM_BYTES),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  logic [7:0] mem [MEM_BYTES];

  // Big-endian combinational instruction memory.
  always_comb begin
    if ({1'b0, bus.imem_addr} + 33'd3 < 33'(MEM_BYTES))
      bus.imem_data = {mem[bus.imem_addr[8:0]], mem[bus.imem_addr[8:0] + 9'd1],
                       mem[bus.imem_addr[8:0] + 9'd2], mem[bus.imem_addr[8:0] + 9'd3]};
    else
      bus.imem_data = 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic [31:0] count;
    logic        valid;
    logic        en;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 running, 1 halted, 2 misaligned.
  int          m_st;
  logic [31:0] m_pc, m_instr, m_pcp4, m_count;
  logic        m_valid;

  function automatic bit fits(input logic [31:0] a);
    return (longint'(a) + 3) < longint'(MEM_BYTES);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i;
    i = int'(a);
    return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
    m_valid = 1'b0; m_count = 32'h0;
  endtask

  task automatic model_step(input bit st, input bit fl, input bit br, input logic [31:0] bt,
                            input bit j, input logic [31:0] jt);
    logic [31:0] npc;
    if (m_st != 0 || !fits(m_pc)) begin
      if (m_st == 0) m_st = 1;
      m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
    end else if (st) begin
      if (fl) begin m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; end
    end else begin
      if (fl) begin
        m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = word_at(m_pc); m_pcp4 = m_pc + 4; m_valid = 1'b1;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end
      npc = j ? jt : (br ? bt : m_pc + 4);
      if (npc % 4 != 0) m_st = 2;
      else begin
        m_pc = npc;
        if (!fits(npc)) m_st = 1;
      end
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge.
  task automatic step(input bit st, input bit fl, input bit br, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
    exp_t x;
    bus.stall = st; bus.flush = fl; bus.branch_taken = br; bus.branch_target = bt;
    bus.jump = j; bus.jump_target = jt;
    model_step(st, fl, br, bt, j, jt);
    x.addr = m_pc; x.instr = m_instr; x.pcp4 = m_pcp4; x.count = m_count;
    x.valid = m_valid; x.en = (m_st == 0); x.halted = (m_st == 1); x.mis = (m_st == 2);
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
    bus.branch_target = 32'h0; bus.jump_target = 32'h0;
    q.delete();
    #1;
    chk("reset_addr_instr_pcp4", bus.imem_addr | bus.id_instr | bus.id_pc_plus4, 32'h0);
    chk("reset_count", bus.fetch_count, 32'h0);
    chk("reset_flags", {28'h0, bus.id_valid, bus.imem_en, bus.halted, bus.misalign_err},
        32'h4);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare DUT against the oldest expectation after each edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr", bus.imem_addr, e.addr);
      chk("id_instr", bus.id_instr, e.instr);
      chk("id_pc_plus4", bus.id_pc_plus4, e.pcp4);
      chk("fetch_count", bus.fetch_count, e.count);
      chk("flags_valid_en_halt_mis_op",
          {20'h0, bus.id_opcode, bus.id_valid, bus.imem_en, bus.halted, bus.misalign_err},
          {20'h0, e.instr[31:26], e.valid, e.en, e.halted, e.mis});
    end
  end

  logic [31:0] rbt, rjt;
  bit rst_, rfl, rbr, rj;

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
    bus.branch_target = 32'h0; bus.jump_target = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    model_reset();
    @(negedge clk);

    // Sequential fetch from reset, then a delay-slot branch at 0x1C.
    do_reset();
    repeat (7) idle();
    step(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 32'h0);
    repeat (2) idle();

    // Stall at pc 0x08, with a flush and an ignored redirect while stalled.
    do_reset();
    repeat (2) idle();
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Jump wins over branch.
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h40);
    repeat (2) idle();

    // Misaligned jump target locks up until reset.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42);
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
    do_reset();
    idle();

    // Run off the end of memory from 0x1F8.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1F8);
    repeat (5) idle();

    // Branch directly beyond memory.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    repeat (2) idle();

    // Randomized traffic with periodic resets.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ((m_st != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rst_ = ($urandom_range(0, 4) == 0);
        rfl  = ($urandom_range(0, 9) == 0);
        rbr  = ($urandom_range(0, 7) == 0);
        rj   = ($urandom_range(0, 15) == 0);
        rbt  = {$urandom_range(0, 135), 2'b00};
        rjt  = {$urandom_range(0, 135), 2'b00};
        if ($urandom_range(0, 40) == 0) rbt = rbt + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 40) == 0) rjt = rjt + 32'($urandom_range(1, 3));
        step(rst_, rfl, rbr, rbt, rj, rjt);
      end
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
